// File: rtl/adma_data_transfer.sv
// Word-level ADMA data mover: RAM->FIFO reads/pushes or FIFO->RAM pops/writes,
// one word every three cycles, with a one-cycle done pulse at the end.
module adma_data_transfer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_STEP  = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic                  direction,
  input  logic [15:0]           length,
  input  logic [63:0]           address_init,
  output logic [63:0]           ram_address,
  output logic                  ram_read_en,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  ram_write_en,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic                  fifo_write_en,
  output logic [DATA_WIDTH-1:0] fifo_write_data,
  output logic                  fifo_read_en,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_RAM    = 3'd1,
    WAIT_RAM  = 3'd2,
    PUSH_FIFO = 3'd3,
    POP_FIFO  = 3'd4,
    WAIT_FIFO = 3'd5,
    WR_RAM    = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam logic [63:0] STEP = 64'(ADDR_STEP);

  state_t                state_r;
  logic                  dir_r;
  logic [15:0]           count_r;
  logic [63:0]           addr_r;
  logic [DATA_WIDTH-1:0] data_r;

  logic push_s;
  logic pop_s;
  logic last_s;

  // Strobes are qualified by the latched direction so a corrupted state cannot cross loops.
  assign push_s = (state_r == PUSH_FIFO) && dir_r && !fifo_full;
  assign pop_s  = (state_r == POP_FIFO) && !dir_r && !fifo_empty;
  assign last_s = (count_r == 16'd1);

  // Transfer sequencer: command latch, word loop, address/count stepping.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
      dir_r   <= 1'b0;
      count_r <= 16'd0;
      addr_r  <= 64'd0;
      data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            dir_r   <= direction;
            count_r <= length;
            addr_r  <= address_init;
            if (length == 16'd0) begin
              state_r <= DONE;
            end else if (direction) begin
              state_r <= RD_RAM;
            end else begin
              state_r <= POP_FIFO;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD_RAM:   state_r <= WAIT_RAM;
        WAIT_RAM: begin
          data_r  <= ram_read_data;
          state_r <= PUSH_FIFO;
        end
        PUSH_FIFO: begin
          if (push_s) begin
            count_r <= count_r - 16'd1;
            addr_r  <= addr_r + STEP;
            state_r <= last_s ? DONE : RD_RAM;
          end else begin
            state_r <= PUSH_FIFO;
          end
        end
        POP_FIFO: begin
          if (pop_s) begin
            state_r <= WAIT_FIFO;
          end else begin
            state_r <= POP_FIFO;
          end
        end
        WAIT_FIFO: begin
          data_r  <= fifo_read_data;
          state_r <= WR_RAM;
        end
        WR_RAM: begin
          count_r <= count_r - 16'd1;
          addr_r  <= addr_r + STEP;
          state_r <= last_s ? DONE : POP_FIFO;
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign ram_address     = addr_r;
  assign ram_write_data  = data_r;
  assign fifo_write_data = data_r;
  assign ram_read_en     = (state_r == RD_RAM) && dir_r;
  assign ram_write_en    = (state_r == WR_RAM) && !dir_r;
  assign fifo_write_en   = push_s;
  assign fifo_read_en    = pop_s;
  assign busy            = (state_r != IDLE) && (state_r != DONE);
  assign done            = (state_r == DONE);

endmodule
